// File: rtl/uar_axi_tx_feeder_if.sv
// -----------------------------------------------------------------------------
// uar_axi_tx_feeder_if
// AXI4 bus bundle between the TX feeder (master) and the UART's AXI slave port.
//   AW : AW_add, AW_valid, AW_ready, AW_len, AW_burst, AW_size
//   W  : W_data, W_strb, W_last, W_valid, W_ready
//   B  : B_response, B_valid, B_ready
//   AR : AR_add, AR_len, AR_burst, AR_size, AR_valid, AR_ready
//   R  : R_data, R_resp, R_last, R_valid, R_ready
// Modports: master (feeder side), slave (UART side).
// -----------------------------------------------------------------------------
interface uar_axi_tx_feeder_if;
    logic [5:0]  AW_add;
    logic        AW_valid;
    logic        AW_ready;
    logic [7:0]  AW_len;
    logic [1:0]  AW_burst;
    logic [2:0]  AW_size;
    logic [31:0] W_data;
    logic [3:0]  W_strb;
    logic        W_last;
    logic        W_valid;
    logic        W_ready;
    logic [1:0]  B_response;
    logic        B_valid;
    logic        B_ready;
    logic [5:0]  AR_add;
    logic [7:0]  AR_len;
    logic [1:0]  AR_burst;
    logic [2:0]  AR_size;
    logic        AR_valid;
    logic        AR_ready;
    logic [31:0] R_data;
    logic [1:0]  R_resp;
    logic        R_last;
    logic        R_valid;
    logic        R_ready;

    modport master (
        output AW_add, AW_valid, AW_len, AW_burst, AW_size,
        output W_data, W_strb, W_last, W_valid,
        output B_ready,
        output AR_add, AR_len, AR_burst, AR_size, AR_valid,
        output R_ready,
        input  AW_ready, W_ready, B_response, B_valid,
        input  AR_ready, R_data, R_resp, R_last, R_valid
    );

    modport slave (
        input  AW_add, AW_valid, AW_len, AW_burst, AW_size,
        input  W_data, W_strb, W_last, W_valid,
        input  B_ready,
        input  AR_add, AR_len, AR_burst, AR_size, AR_valid,
        input  R_ready,
        output AW_ready, W_ready, B_response, B_valid,
        output AR_ready, R_data, R_resp, R_last, R_valid
    );
endinterface

// File: rtl/uar_axi_tx_feeder.sv
// -----------------------------------------------------------------------------
// uar_axi_tx_feeder
// AXI4 master feeding bytes into a UART TX FIFO. Each accepted byte is held
// while the UART status register is polled (AR/R) until TxFull is clear, then
// written to the TX data register (AW/W/B). Bytes are dropped on an error
// response or after MAX_POLLS full readings; drop_flag records this stickily.
//
// Ports:
//   Clk, Rst_n        clock, asynchronous active-low reset
//   s_data/s_valid/s_ready   local byte stream (valid/ready)
//   axi               AXI4 master modport (uar_axi_tx_feeder_if.master)
//   drop_clr          synchronous clear of drop_flag (set wins)
//   busy              FSM not in IDLE
//   drop_flag         sticky byte-dropped indicator
//   tx_count, drop_count   (only with UAR_FEEDER_STATS_EN) 16-bit wrapping
//                     counts of successful writes and drop events
//
// Build option: define UAR_FEEDER_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module uar_axi_tx_feeder #(
    parameter logic [5:0]  TX_DATA_ADDR = 6'h04,
    parameter logic [5:0]  STATUS_ADDR  = 6'h08,
    parameter int unsigned TXFULL_BIT   = 5,
    parameter int unsigned POLL_GAP     = 4,
    parameter int unsigned MAX_POLLS    = 255
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    output logic                s_ready,
    uar_axi_tx_feeder_if.master axi,
    input  logic                drop_clr,
`ifdef UAR_FEEDER_STATS_EN
    output logic [15:0]         tx_count,
    output logic [15:0]         drop_count,
`endif
    output logic                busy,
    output logic                drop_flag
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_GAP,
        ST_WR,
        ST_B
    } state_e;

    localparam logic [7:0]  MAX_POLLS_C = 8'(MAX_POLLS);
    localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);

    state_e      state_q;
    logic [7:0]  data_q;
    logic [7:0]  poll_cnt_q;
    logic [7:0]  poll_cnt_d;
    logic [15:0] gap_cnt_q;
    logic        s_ready_q;
    logic        ar_valid_q;
    logic        r_ready_q;
    logic        aw_valid_q;
    logic        w_valid_q;
    logic        b_ready_q;
    logic        busy_q;
    logic        drop_flag_q;
    logic        aw_done_d;
    logic        w_done_d;
    logic        r_hs;
    logic        b_hs;
    logic        drop_set_d;

    // Status data bits other than TxFull and R_last carry no information here.
    logic        unused_rd;
    assign unused_rd = ^{axi.R_last, axi.R_data};

    always_comb begin
        poll_cnt_d = poll_cnt_q + 8'd1;
        // A channel counts as done if it already handshook or does so now.
        aw_done_d  = !aw_valid_q || axi.AW_ready;
        w_done_d   = !w_valid_q  || axi.W_ready;
        r_hs       = (state_q == ST_R) && r_ready_q && axi.R_valid;
        b_hs       = (state_q == ST_B) && b_ready_q && axi.B_valid;
        drop_set_d = 1'b0;
        if (r_hs && (axi.R_resp != 2'b00)) begin
            drop_set_d = 1'b1;
        end else if (r_hs && axi.R_data[TXFULL_BIT] && (poll_cnt_d == MAX_POLLS_C)) begin
            drop_set_d = 1'b1;
        end else if (b_hs && (axi.B_response != 2'b00)) begin
            drop_set_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            poll_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            s_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            drop_flag_q <= 1'b0;
        end else begin
            if (drop_set_d) begin
                drop_flag_q <= 1'b1;
            end else if (drop_clr) begin
                drop_flag_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (s_ready_q && s_valid) begin
                        data_q     <= s_data;
                        poll_cnt_q <= '0;
                        s_ready_q  <= 1'b0;
                        ar_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_AR;
                    end else begin
                        s_ready_q  <= 1'b1;
                    end
                end

                ST_AR: begin
                    if (axi.AR_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= ST_R;
                    end
                end

                ST_R: begin
                    if (r_hs) begin
                        r_ready_q <= 1'b0;
                        if (axi.R_resp != 2'b00) begin
                            s_ready_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= ST_IDLE;
                        end else if (axi.R_data[TXFULL_BIT]) begin
                            poll_cnt_q <= poll_cnt_d;
                            if (poll_cnt_d == MAX_POLLS_C) begin
                                s_ready_q <= 1'b1;
                                busy_q    <= 1'b0;
                                state_q   <= ST_IDLE;
                            end else if (POLL_GAP == 0) begin
                                ar_valid_q <= 1'b1;
                                state_q    <= ST_AR;
                            end else begin
                                gap_cnt_q <= '0;
                                state_q   <= ST_GAP;
                            end
                        end else begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state_q    <= ST_WR;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        ar_valid_q <= 1'b1;
                        state_q    <= ST_AR;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end

                ST_WR: begin
                    if (axi.AW_ready) begin
                        aw_valid_q <= 1'b0;
                    end
                    if (axi.W_ready) begin
                        w_valid_q <= 1'b0;
                    end
                    if (aw_done_d && w_done_d) begin
                        b_ready_q <= 1'b1;
                        state_q   <= ST_B;
                    end
                end

                ST_B: begin
                    if (b_hs) begin
                        b_ready_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end

                default: begin
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b0;
                    aw_valid_q <= 1'b0;
                    w_valid_q  <= 1'b0;
                    b_ready_q  <= 1'b0;
                    s_ready_q  <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UAR_FEEDER_STATS_EN
    logic [15:0] tx_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (b_hs && (axi.B_response == 2'b00)) begin
                tx_cnt_q <= tx_cnt_q + 16'd1;
            end
            if (drop_set_d) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign tx_count   = tx_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

    assign s_ready      = s_ready_q;
    assign busy         = busy_q;
    assign drop_flag    = drop_flag_q;

    assign axi.AW_add   = TX_DATA_ADDR;
    assign axi.AW_valid = aw_valid_q;
    assign axi.AW_len   = 8'h00;
    assign axi.AW_burst = 2'b01;
    assign axi.AW_size  = 3'b010;
    assign axi.W_data   = {24'h000000, data_q};
    assign axi.W_strb   = 4'b0001;
    assign axi.W_last   = w_valid_q;
    assign axi.W_valid  = w_valid_q;
    assign axi.B_ready  = b_ready_q;
    assign axi.AR_add   = STATUS_ADDR;
    assign axi.AR_len   = 8'h00;
    assign axi.AR_burst = 2'b01;
    assign axi.AR_size  = 3'b010;
    assign axi.AR_valid = ar_valid_q;
    assign axi.R_ready  = r_ready_q;

endmodule

// File: doc/uar_axi_tx_feeder.md
Name: uar_axi_tx_feeder

Overview:
- AXI4 master that sits directly upstream of the UART's AXI slave port.
- Accepts a local byte stream over a valid/ready handshake.
- For each byte: polls the UART status register over the AR/R channels until the TX FIFO is not full, then writes the byte to the TX data register over AW/W/B.
- Lets a non-AXI producer (command engine, test sequencer) drive the RS232 TX path without software.

Parameters:
TX_DATA_ADDR, 6'h04, AXI address of the UART TX data register.
STATUS_ADDR, 6'h08, AXI address of the UART status register.
TXFULL_BIT, 5, bit index of TxFull inside R_data of a status read.
POLL_GAP, 4, idle cycles between consecutive status reads while TX FIFO full (0 allowed).
MAX_POLLS, 255, status reads with TxFull=1 before the byte is dropped (8-bit counter, 1..255).

Ports:
Clk  in  1  clock
Rst_n  in  1  asynchronous active-low reset
s_data  in  8  byte to transmit
s_valid  in  1  s_data valid
s_ready  out  1  feeder can accept a byte
AW_add  out  6  write address, always TX_DATA_ADDR
AW_valid  out  1  write address valid
AW_ready  in  1  write address ready
AW_len  out  8  constant 0 (single beat)
AW_burst  out  2  constant 2'b01 (INCR)
AW_size  out  3  constant 3'b010 (4 bytes)
W_data  out  32  {24'h0, captured byte}
W_strb  out  4  constant 4'b0001
W_last  out  1  equals W_valid
W_valid  out  1  write data valid
W_ready  in  1  write data ready
B_response  in  2  write response
B_valid  in  1  write response valid
B_ready  out  1  write response ready
AR_add  out  6  read address, always STATUS_ADDR
AR_len  out  8  constant 0
AR_burst  out  2  constant 2'b01
AR_size  out  3  constant 3'b010
AR_valid  out  1  read address valid
AR_ready  in  1  read address ready
R_data  in  32  read data
R_resp  in  2  read response
R_last  in  1  read last (ignored; single beat)
R_valid  in  1  read data valid
R_ready  out  1  read data ready
busy  out  1  state != IDLE
drop_flag  out  1  sticky: a byte was dropped (error response or poll limit)
drop_clr  in  1  synchronous clear of drop_flag

Behaviour:
- All outputs are registered. During reset and in the first cycle after reset, every valid/ready output, busy and drop_flag are 0 and the poll counters are 0.
- FSM states: IDLE, AR, R, GAP, WR, B.
- IDLE:
  - s_ready=1.
  - On s_valid&s_ready: capture the byte, clear poll_cnt, s_ready=0 next cycle, go to AR. AR_valid rises in the cycle after acceptance.
- AR:
  - AR_valid held 1 until AR_valid&AR_ready, then AR_valid=0 and go to R.
  - AR_add is stable while AR_valid=1.
- R: R_ready=1 until R_valid. On R_valid:
  - R_resp != 2'b00 -> set drop_flag, discard the byte, go to IDLE.
  - R_resp OKAY and R_data[TXFULL_BIT]=1 -> poll_cnt+1. If the new poll_cnt == MAX_POLLS, set drop_flag and go to IDLE; else go to GAP.
  - R_resp OKAY and TxFull=0 -> go to WR.
- GAP:
  - Count POLL_GAP cycles, then go to AR.
  - POLL_GAP=0 goes straight to AR with no idle cycle.
- WR:
  - AW_valid and W_valid are raised in the same cycle.
  - Each drops independently on its own handshake; the two handshakes may be in either order or the same cycle.
  - Go to B once both handshakes are done.
  - Never deassert a valid before its handshake. Payload is stable while valid.
- B:
  - B_ready=1 until B_valid; then go to IDLE.
  - B_response != OKAY sets drop_flag. The byte is not retried.
- Minimum per byte with zero-wait slave: accept -> AR -> R -> WR -> B -> IDLE, 5 cycles between consecutive s_ready acceptances.
- drop_flag: set has priority over drop_clr in the same cycle.
- Reset asserted mid-transaction: immediate return to IDLE with all valids low. The captured byte is lost and no completion is reported.
- Inputs R_valid and B_valid outside states R and B are ignored; the slave must not produce them.

Optional Feature:
- Macro UAR_FEEDER_STATS_EN.
- When defined, adds output ports tx_count[15:0] and drop_count[15:0], both reset to 0:
  - tx_count increments on each B handshake with OKAY.
  - drop_count increments on every drop_flag set event.
  - Both wrap 16'hFFFF->0 and are not cleared by drop_clr.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Zero-wait slave, status reads 0, bytes 8'h41,8'h42 back to back -> two writes to 6'h04 with W_data 32'h41 then 32'h42, W_strb 4'b0001, second s_ready acceptance 5 cycles after the first, drop_flag 0.
- Status returns bit5=1 three times then 0, POLL_GAP=4 -> exactly 4 AR handshakes, 4 idle cycles between reads, then 1 write.
- Status always full, MAX_POLLS=3 -> 3 reads, no AW_valid, drop_flag=1, IDLE; drop_clr pulse -> drop_flag=0.
- Slave holds AW_ready low 3 cycles while accepting W immediately -> W_valid drops after 1 cycle, AW_valid held with stable AW_add 6'h04 until accepted, then B_ready.
- R_resp=2'b10 on status read -> no write, drop_flag=1; B_response=2'b10 on write -> drop_flag=1, next byte still processed normally.
- Rst_n pulsed low while AW_valid=1 -> AW_valid, W_valid, busy go 0 asynchronously; after release s_ready=1 in IDLE.
